axis_keep_unpacker: RTL

// - Wide-to-narrow AXIS unpacker driven by tkeep; receive-side counterpart to packers that zero-pad on early tlast.
// - Emits only lanes holding valid bytes and drops null lanes.
// - Full throughput: one narrow beat per cycle, no bubble between input words.
// - Sits after wide DMA/MAC datapaths, ahead of byte-oriented parsers.

---
 rtl/axis_pkg.sv | 26 ++
 rtl/axis_lane_select.sv | 31 +++
 rtl/axis_keep_unpacker.sv | 99 +++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXIS helpers: lane-activity masks built from tkeep and a one-hot test,
// sized for the widest stream the keep-aware packers and unpackers handle.
package axis_pkg;

  localparam int MAX_KEEP = 64;
  localparam int KEEP_IDX_W = $clog2(MAX_KEEP);

  typedef logic [MAX_KEEP-1:0] lane_mask_t;

  // A lane is active when any of its o_bytes keep bits is set.
  function automatic lane_mask_t lane_active(input lane_mask_t keep, input int o_bytes);
    lane_mask_t mask;
    logic [KEEP_IDX_W-1:0] lane;
    mask = '0;
    for (int b = 0; b < MAX_KEEP; b++) begin
      lane = KEEP_IDX_W'(b / o_bytes);
      if (keep[KEEP_IDX_W'(b)]) mask[lane] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic popcount_is_one(input lane_mask_t mask);
    return (mask != '0) && ((mask & (mask - lane_mask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_lane_select.sv
// Priority encoder over a remaining-lane mask: picks the lowest set lane
// (highest when MSB_FIRST) and reports it both one-hot and as an index.
module axis_lane_select #(
  parameter int RATIO = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic [RATIO-1:0] rem,
  output logic [RATIO-1:0] sel,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int j;

  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < RATIO; i++) begin
      j = MSB_FIRST ? (RATIO - 1 - i) : i;
      if (!found && rem[IDX_W'(j)]) begin
        found = 1'b1;
        sel[IDX_W'(j)] = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axis_keep_unpacker.sv
// Wide-to-narrow AXIS unpacker: splits each input word into its tkeep-active
// lanes, one narrow beat per cycle, with no bubble between consecutive words.
module axis_keep_unpacker
  import axis_pkg::*;
#(
  parameter int AXIS_I_BYTES = 4,
  parameter int AXIS_O_BYTES = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      sresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_I_BYTES*8-1:0] axis_i_tdata,
  input  logic [AXIS_I_BYTES-1:0]   axis_i_tkeep,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_O_BYTES*8-1:0] axis_o_tdata,
  output logic [AXIS_O_BYTES-1:0]   axis_o_tkeep
);

  localparam int RATIO = AXIS_I_BYTES / AXIS_O_BYTES;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int O_BITS = AXIS_O_BYTES * 8;

  if ((AXIS_I_BYTES % AXIS_O_BYTES) != 0 || AXIS_I_BYTES < AXIS_O_BYTES
      || AXIS_I_BYTES > MAX_KEEP) begin : g_bad_ratio
    $error("axis_keep_unpacker: AXIS_I_BYTES must be a multiple of AXIS_O_BYTES and at most 64");
  end

  if (RATIO == 1) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl   = clk ^ sresetn;
    assign axis_i_tready = axis_o_tready;
    assign axis_o_tvalid = axis_i_tvalid;
    assign axis_o_tlast  = axis_i_tlast;
    assign axis_o_tdata  = axis_i_tdata;
    assign axis_o_tkeep  = axis_i_tkeep;
  end else begin : g_unpack
    logic [AXIS_I_BYTES*8-1:0] data_q;
    logic [AXIS_I_BYTES-1:0]   keep_q;
    logic                      last_q;
    logic [RATIO-1:0]          rem_q;
    logic [RATIO-1:0]          rem_load;
    logic [RATIO-1:0]          sel;
    logic [IDX_W-1:0]          idx;
    logic                      rem_one;
    logic                      in_fire;
    logic                      out_fire;

    axis_lane_select #(
      .RATIO(RATIO),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane_select (
      .rem(rem_q),
      .sel(sel),
      .idx(idx)
    );

    // A keep-less tlast word still emits one empty beat so the packet end survives.
    always_comb begin
      rem_one  = popcount_is_one(lane_mask_t'(rem_q));
      rem_load = RATIO'(lane_active(lane_mask_t'(axis_i_tkeep), AXIS_O_BYTES));
      if (axis_i_tkeep == '0 && axis_i_tlast) begin
        rem_load = '0;
        rem_load[MSB_FIRST ? RATIO - 1 : 0] = 1'b1;
      end
    end

    assign axis_i_tready = sresetn && (rem_q == '0 || (axis_o_tready && rem_one));
    assign in_fire       = axis_i_tvalid && axis_i_tready;
    assign out_fire      = axis_o_tvalid && axis_o_tready;

    assign axis_o_tvalid = (rem_q != '0);
    assign axis_o_tdata  = data_q[idx * O_BITS +: O_BITS];
    assign axis_o_tkeep  = keep_q[idx * AXIS_O_BYTES +: AXIS_O_BYTES];
    assign axis_o_tlast  = last_q && rem_one;

    // Accepting a new word can only coincide with popping the final lane, so the load wins.
    always_ff @(posedge clk) begin
      if (!sresetn) begin
        rem_q  <= '0;
        data_q <= '0;
        keep_q <= '0;
        last_q <= 1'b0;
      end else if (in_fire) begin
        data_q <= axis_i_tdata;
        keep_q <= axis_i_tkeep;
        last_q <= axis_i_tlast;
        rem_q  <= rem_load;
      end else if (out_fire) begin
        rem_q <= rem_q & ~sel;
      end
    end
  end

endmodule
